// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and width constants for mul_seq.
package mul_pkg;
  localparam int DEF_W = 4;
  localparam int CNT_W = $clog2(DEF_W);
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-and-add D = q*d + r; optional rem_ok flag with MUL_SEQ_CHECK_EN.
module mul_seq
  import mul_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   d,
  input  logic [W-1:0]   r,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] D
`ifdef MUL_SEQ_CHECK_EN
  ,
  output logic           rem_ok
`endif
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  state_t state;
  logic [2*W-1:0] acc, mcand, sum;
  logic [W-1:0] mplier;
  logic [CW-1:0] cnt;
  logic accept, last;
  assign accept = start && (state != RUN);
  assign last = (state == RUN) && (cnt == CW'(W - 1));
  assign sum = acc + (mplier[0] ? mcand : '0);
  assign busy = (state == RUN);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      D      <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mcand  <= {{W{1'b0}}, d};
        mplier <= q;
        acc    <= {{W{1'b0}}, r};
        cnt    <= '0;
        state  <= RUN;
      end else if (state == RUN) begin
        acc    <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last) begin
          state <= DONE;
          D     <= sum;
          done  <= 1'b1;
        end
      end else
        state <= IDLE;
    end
`ifdef MUL_SEQ_CHECK_EN
  logic legal;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      legal  <= 1'b0;
      rem_ok <= 1'b0;
    end else begin
      if (accept) legal <= (d != '0) && (r < d);
      if (last) rem_ok <= legal;
    end
`endif
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed vectors with hand-computed results for mul_seq (W=4).
module tb_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] q = '0, d = '0, r = '0;
  logic busy, done;
  logic [7:0] D;
  int checks = 0;
  int errors = 0;
`ifdef MUL_SEQ_CHECK_EN
  logic rem_ok;
`endif
  mul_seq #(.W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .q(q), .d(d), .r(r),
    .busy(busy), .done(done), .D(D)
`ifdef MUL_SEQ_CHECK_EN
    , .rem_ok(rem_ok)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic op(input logic [3:0] a, b, c, input logic [7:0] exp, input string tag);
    int n;
    @(negedge clk);
    q = a; d = b; r = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_done(n);
    check({tag, "_lat"}, n, 4);
    check({tag, "_D"}, D, exp);
    @(posedge clk);
    #1 check({tag, "_pulse"}, done, 0);
  endtask
  initial begin
    int n;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_D", D, 0);
`ifdef MUL_SEQ_CHECK_EN
    check("rst_remok", rem_ok, 0);
`endif
    @(negedge clk) rst = 1'b0;
    op(4'd7, 4'd2, 4'd1, 8'd15, "basic");
`ifdef MUL_SEQ_CHECK_EN
    check("basic_remok", rem_ok, 1);
`endif
    op(4'd0, 4'd2, 4'd0, 8'd0, "q0");
    op(4'd5, 4'd0, 4'd3, 8'd3, "d0");
`ifdef MUL_SEQ_CHECK_EN
    check("d0_remok", rem_ok, 0);
`endif
    op(4'd15, 4'd15, 4'd15, 8'd240, "max");
`ifdef MUL_SEQ_CHECK_EN
    op(4'd1, 4'd2, 4'd3, 8'd5, "rbig");
    check("rbig_remok", rem_ok, 0);
`endif
    // back-to-back: start held through DONE
    @(negedge clk);
    q = 4'd3; d = 4'd3; r = 4'd2; start = 1'b1;
    @(posedge clk);
    #1 wait_done(n);
    check("b2b1_lat", n, 4);
    check("b2b1_D", D, 11);
    q = 4'd1; d = 4'd4; r = 4'd0;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_nodone", done, 0);
    n = 1;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b2_gap", n, 5);
    check("b2b2_D", D, 4);
    // start mid-RUN is ignored
    @(negedge clk);
    q = 4'd6; d = 4'd5; r = 4'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 q = 4'd1; d = 4'd1; r = 4'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
    check("mid_lat", n, 2);
    check("mid_D", D, 34);
    @(posedge clk);
    #1 check("mid_idle", busy, 0);
    // reset mid-operation
    @(negedge clk);
    q = 4'd9; d = 4'd9; r = 4'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_D", D, 0);
    check("arst_done", done, 0);
    @(negedge clk) rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 if (done) n++;
    end
    check("arst_nopulse", n, 0);
    op(4'd2, 4'd3, 4'd1, 8'd7, "post_rst");
`ifdef MUL_SEQ_CHECK_EN
    check("post_rst_remok", rem_ok, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
